mod_add_arb: RTL

MOD_ADD_ARB -- requirements
Module: mod_add_arb

---
 rtl/mod_add_arb.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mod_add_arb.sv
// mod_add_arb: N_REQ requesters share a single modular adder through an
// arbiter feeding a two-stage valid/ready pipeline.
//   S1 holds the granted operands, the modulus captured at accept time and
//      the requester id; mod_add evaluates combinationally on S1.
//   S2 holds the reduced result and id presented on the result port.
// Optional feature macro: MOD_ADD_ARB_RR_EN
//   defined   -> round-robin arbitration with a pointer register
//   undefined -> fixed priority, lowest valid index wins (no pointer)

// Single modular adder: c = (a + b) mod q, valid for a, b < q.
module mod_add (
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic [22:0] q,
    output logic [22:0] c
);

    logic [24:0] sum;
    logic [24:0] q_ext;
    logic [24:0] red;
    logic [1:0]  unused_hi;

    // One conditional subtract is enough because a + b < 2q.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        q_ext = {2'b00, q};
        red   = (sum >= q_ext) ? (sum - q_ext) : sum;
    end

    assign {unused_hi, c} = red;

endmodule

module mod_add_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ*24-1:0]   req_a_i,
    input  logic [N_REQ*24-1:0]   req_b_i,
    input  logic [22:0]           q_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [22:0]           res_c_o,
    output logic [ID_W-1:0]       res_id_o
);

    // Stage 1: operands, modulus and id of the accepted operation.
    logic            s1_valid;
    logic [23:0]     s1_a;
    logic [23:0]     s1_b;
    logic [22:0]     s1_q;
    logic [ID_W-1:0] s1_id;

    // Stage 2: reduced result waiting for the consumer.
    logic            s2_valid;
    logic [22:0]     s2_c;
    logic [ID_W-1:0] s2_id;

    // Pipeline flow control.
    logic            s1_adv;
    logic            s2_adv;
    logic            accept;

    // Arbiter results.
    logic [N_REQ-1:0] grant_vec;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;

    // Operands of the granted requester.
    logic [23:0]      sel_a;
    logic [23:0]      sel_b;

    logic [22:0]      mod_c;

    assign s2_adv      = !s2_valid || res_ready_i;
    assign s1_adv      = !s1_valid || s2_adv;
    assign req_ready_o = (rst_n_i && s1_adv) ? grant_vec : '0;
    assign accept      = grant_any && rst_n_i && s1_adv;

`ifdef MOD_ADD_ARB_RR_EN

    logic [ID_W-1:0] ptr;

    // Round-robin search: first valid index at or above the pointer, else the
    // lowest valid index overall (which then lies below the pointer).
    always_comb begin
        grant_vec = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!grant_any && req_valid_i[j] && (ID_W'(j) >= ptr)) begin
                grant_any    = 1'b1;
                grant_vec[j] = 1'b1;
                grant_id     = ID_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!grant_any && req_valid_i[j]) begin
                grant_any    = 1'b1;
                grant_vec[j] = 1'b1;
                grant_id     = ID_W'(j);
            end
        end
    end

    // Pointer moves just past the requester that was actually accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

`else

    // Fixed priority: lowest valid index wins.
    always_comb begin
        grant_vec = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!grant_any && req_valid_i[j]) begin
                grant_any    = 1'b1;
                grant_vec[j] = 1'b1;
                grant_id     = ID_W'(j);
            end
        end
    end

`endif

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (grant_vec[j]) begin
                sel_a = req_a_i[j*24 +: 24];
                sel_b = req_b_i[j*24 +: 24];
            end
        end
    end

    // Stage 1 captures the granted operation and the modulus of this cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_q     <= '0;
            s1_id    <= '0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_q  <= q_i;
                s1_id <= grant_id;
            end
        end
    end

    mod_add u_mod_add (
        .a (s1_a),
        .b (s1_b),
        .q (s1_q),
        .c (mod_c)
    );

    // Stage 2 holds its result steady until the consumer takes it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid <= 1'b0;
            s2_c     <= '0;
            s2_id    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_c  <= mod_c;
                s2_id <= s1_id;
            end
        end
    end

    assign res_valid_o = s2_valid;
    assign res_c_o     = s2_c;
    assign res_id_o    = s2_id;

endmodule
